// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer for a req/gnt/rvalid memory, drives the F/D register
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcM,
    input  logic [31:0] PCBranchM,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstructionD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state;
    logic        discard;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic [31:0] pc_plus4;

    assign pc_plus4  = PCF + 32'd4;
    // Request is a pure decode of registered state; gated off while reset is held.
    assign imem_req  = (state == S_REQ) && !rst;
    assign imem_addr = PCF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            discard      <= 1'b0;
            PCF          <= RESET_PC;
            InstructionD <= NOP_INSTR;
            PCPlus4D     <= 32'd0;
            ValidD       <= 1'b0;
            hold_instr   <= NOP_INSTR;
            hold_pc4     <= 32'd0;
        end else if (PCSrcM) begin
            PCF          <= PCBranchM;
            InstructionD <= NOP_INSTR;
            ValidD       <= 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state   <= S_WAIT;
                        discard <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state   <= S_REQ;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            // Bubble by default; overridden below when an instruction moves into D.
            if (!StallD) begin
                InstructionD <= NOP_INSTR;
                ValidD       <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            PCF <= pc_plus4;
                            if (!StallD) begin
                                InstructionD <= imem_rdata;
                                PCPlus4D     <= pc_plus4;
                                ValidD       <= 1'b1;
                                state        <= S_REQ;
                            end else begin
                                hold_instr <= imem_rdata;
                                hold_pc4   <= pc_plus4;
                                state      <= S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        InstructionD <= hold_instr;
                        PCPlus4D     <= hold_pc4;
                        ValidD       <= 1'b1;
                        state        <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcM = 1'b0;
    logic [31:0] PCBranchM = 32'd0;
    logic        StallD = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] PCF;
    logic [31:0] InstructionD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          c0 = 0;
    int          gnt_delay = 0;
    int          rv_delay = 0;

    exp_t        sb[$];
    int          load_cyc[$];
    logic [31:0] load_pc[$];

    logic        m_busy = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_req_s = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_addr_s = 32'd0;
    logic [31:0] exp_pc = 32'd0;
    int          m_wcnt = 0;
    int          m_rcnt = 0;

    logic        rst_e, stall_e, red_e;
    logic [31:0] prev_instr, prev_pc4;
    logic        prev_valid;

    fetch_sequencer dut (
        .clk(clk),
        .rst(rst),
        .PCSrcM(PCSrcM),
        .PCBranchM(PCBranchM),
        .StallD(StallD),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .PCF(PCF),
        .InstructionD(InstructionD),
        .PCPlus4D(PCPlus4D),
        .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lp(input int i);
        return (load_pc.size() > i) ? load_pc[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int lc(input int i);
        return (load_cyc.size() > i) ? load_cyc[i] : -1;
    endfunction

    // Memory model: configurable gnt/rvalid delays, rdata = addr ^ A5A5_0000.
    // It also keeps the expected PC and pushes the expected D contents for every response that must survive.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            m_req_s     = imem_req;
            m_addr_s    = imem_addr;
            imem_gnt    = !m_busy && m_req_s && (m_wcnt >= gnt_delay);
            imem_rvalid = m_busy && (m_rcnt >= rv_delay);
            imem_rdata  = m_busy ? (m_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
            @(posedge clk);
            if (rst) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
                m_wcnt  = 0;
                m_rcnt  = 0;
                exp_pc  = 32'd0;
                sb.delete();
            end else begin
                if (!m_busy) begin
                    if (imem_gnt) begin
                        check("gnt_addr", m_addr_s, exp_pc);
                        m_busy  = 1'b1;
                        m_addr  = m_addr_s;
                        m_stale = PCSrcM;
                        m_rcnt  = 0;
                        m_wcnt  = 0;
                    end else if (m_req_s) begin
                        m_wcnt++;
                    end
                end else if (imem_rvalid) begin
                    m_busy = 1'b0;
                    if (!(m_stale || PCSrcM)) begin
                        exp_t e;
                        e.instr = exp_pc ^ 32'hA5A5_0000;
                        e.pc4   = exp_pc + 32'd4;
                        sb.push_back(e);
                        exp_pc = exp_pc + 32'd4;
                    end
                end else begin
                    m_rcnt++;
                    m_stale = m_stale | PCSrcM;
                end
                if (PCSrcM) exp_pc = PCBranchM;
            end
        end
    end

    // D-stage monitor: every edge is a redirect, a stall hold, a load, or a bubble.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_e   = rst;
            stall_e = StallD;
            red_e   = PCSrcM;
            #1;
            if (!rst_e) begin
                if (red_e) begin
                    check("redir_valid", ValidD, 0);
                    check("redir_nop", InstructionD, NOP);
                    check("redir_pc4_hold", PCPlus4D, prev_pc4);
                end else if (stall_e) begin
                    check("stall_instr", InstructionD, prev_instr);
                    check("stall_pc4", PCPlus4D, prev_pc4);
                    check("stall_valid", ValidD, prev_valid);
                end else if (ValidD) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("load_instr", InstructionD, e.instr);
                        check("load_pc4", PCPlus4D, e.pc4);
                    end
                    load_cyc.push_back(cyc);
                    load_pc.push_back(PCPlus4D);
                end else begin
                    check("bubble_nop", InstructionD, NOP);
                    check("bubble_pc4_hold", PCPlus4D, prev_pc4);
                end
            end
            prev_instr = InstructionD;
            prev_pc4   = PCPlus4D;
            prev_valid = ValidD;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    task automatic wait_loads(input int n, input int budget);
        int t = 0;
        while (load_cyc.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("load_timeout", load_cyc.size() >= n, 1);
    endtask

    task automatic do_reset(input int gd, input int rd);
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        rst       = 1'b1;
        PCSrcM    = 1'b0;
        StallD    = 1'b0;
        gnt_delay = gd;
        rv_delay  = rd;
        repeat (2) @(negedge clk);
        check("reset_req", imem_req, 0);
        check("reset_pcf", PCF, 32'd0);
        check("reset_instr", InstructionD, NOP);
        check("reset_pc4", PCPlus4D, 32'd0);
        check("reset_valid", ValidD, 0);
        rst = 1'b0;
        c0  = cyc;
        load_cyc.delete();
        load_pc.delete();
    endtask

    initial begin
        // zero-wait streaming
        do_reset(0, 0);
        wait_loads(3, 20);
        check("zw_cyc0", lc(0), c0 + 2);
        check("zw_cyc1", lc(1), c0 + 4);
        check("zw_cyc2", lc(2), c0 + 6);
        check("zw_pc0", lp(0), 32'd4);
        check("zw_pc1", lp(1), 32'd8);
        check("zw_pc2", lp(2), 32'd12);

        // gnt delayed 3, rvalid delayed 2 more
        do_reset(3, 2);
        for (int k = 0; k < 4; k++) begin
            #2;
            check("slow_req", imem_req, 1);
            check("slow_addr", imem_addr, 32'd0);
            check("slow_valid", ValidD, 0);
            @(negedge clk);
        end
        wait_loads(1, 20);
        check("slow_cyc", lc(0), c0 + 7);
        check("slow_pc", lp(0), 32'd4);

        // stall around the second response
        do_reset(0, 0);
        repeat (2) @(negedge clk);
        StallD = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_req", imem_req, 0);
        check("hold_pcf", PCF, 32'd8);
        check("hold_d_valid", ValidD, 1);
        check("hold_d_pc4", PCPlus4D, 32'd4);
        @(negedge clk);
        check("hold_req2", imem_req, 0);
        @(negedge clk);
        StallD = 1'b0;
        wait_loads(2, 20);
        check("hold_cyc", lc(1), c0 + 7);
        check("hold_pc", lp(1), 32'd8);

        // redirect while waiting for rvalid
        do_reset(0, 3);
        @(negedge clk);
        PCSrcM    = 1'b1;
        PCBranchM = 32'h0000_0100;
        @(negedge clk);
        PCSrcM = 1'b0;
        check("rw_pcf", PCF, 32'h100);
        check("rw_req", imem_req, 0);
        check("rw_valid", ValidD, 0);
        begin
            int t = 0;
            while (!imem_req && t < 10) begin
                @(negedge clk);
                t++;
            end
        end
        check("rw_req_seen", imem_req, 1);
        check("rw_addr", imem_addr, 32'h100);
        wait_loads(1, 40);
        check("rw_pc", lp(0), 32'h104);

        // redirect coinciding with gnt
        do_reset(1, 1);
        @(negedge clk);
        PCSrcM    = 1'b1;
        PCBranchM = 32'h0000_0200;
        @(negedge clk);
        PCSrcM = 1'b0;
        check("rg_pcf", PCF, 32'h200);
        check("rg_valid", ValidD, 0);
        wait_loads(1, 40);
        check("rg_pc", lp(0), 32'h204);

        // redirect coinciding with rvalid
        do_reset(0, 1);
        repeat (2) @(negedge clk);
        PCSrcM    = 1'b1;
        PCBranchM = 32'h0000_0300;
        @(negedge clk);
        PCSrcM = 1'b0;
        check("rv_pcf", PCF, 32'h300);
        check("rv_valid", ValidD, 0);
        check("rv_req", imem_req, 1);
        wait_loads(1, 40);
        check("rv_pc", lp(0), 32'h304);

        // reset during WAIT
        do_reset(0, 0);
        wait_loads(2, 20);
        rv_delay = 5;
        @(negedge clk);
        check("mr_wait_req", imem_req, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mr_req", imem_req, 0);
        check("mr_pcf", PCF, 32'd0);
        check("mr_instr", InstructionD, NOP);
        check("mr_pc4", PCPlus4D, 32'd0);
        check("mr_valid", ValidD, 0);
        rst      = 1'b0;
        rv_delay = 0;
        c0       = cyc;
        load_cyc.delete();
        load_pc.delete();
        wait_loads(1, 20);
        check("mr_restart_pc", lp(0), 32'd4);

        // PC wrap from FFFF_FFFC, redirect in REQ without gnt
        do_reset(1, 0);
        PCSrcM    = 1'b1;
        PCBranchM = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSrcM = 1'b0;
        #2;
        check("wrap_req", imem_req, 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_loads(1, 20);
        check("wrap_pc4", lp(0), 32'd0);
        check("wrap_pcf", PCF, 32'd0);
        check("wrap_next_req", imem_req, 1);
        check("wrap_next_addr", imem_addr, 32'd0);
        repeat (2) @(negedge clk);
        check("sb_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls the instruction-fetch stage of the pipelined core when instruction memory has variable latency and uses a req/gnt/rvalid handshake. It owns PCF and issues fetch requests. Branch redirects from the M stage can arrive at any point, including while a fetch is in flight; stale responses are discarded. Decode stalls are absorbed in a one-entry hold buffer. It drives the F/D pipeline register (InstructionD, PCPlus4D, ValidD) in place of a fixed-latency fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP_INSTR, 32'h0000_0013, instruction word driven into D on reset, bubble or flush

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- PCSrcM  in  1  redirect request from the M stage
- PCBranchM  in  32  redirect target
- StallD  in  1  decode stall; D registers must hold
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; always equals PCF
- imem_gnt  in  1  memory accepted the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- PCF  out  32  current fetch PC
- InstructionD  out  32  instruction presented to decode
- PCPlus4D  out  32  fetched PC + 4 for the instruction in D
- ValidD  out  1  InstructionD is a real instruction, not a bubble

## Operation
- States:
  - REQ: imem_req=1.
  - WAIT: one request is outstanding.
  - HOLD: a response is buffered because StallD was high.
- At most one request is outstanding. imem_rvalid is guaranteed only in WAIT, and at least 1 cycle after the gnt.
- REQ:
  - imem_gnt=1 moves the state to WAIT.
  - imem_addr may change while waiting for gnt, but only due to a redirect.
- WAIT, on imem_rvalid with discard=0:
  - PCF <= PCF+4.
  - If StallD=0: D <= {imem_rdata, PCF+4, valid}, and the state moves to REQ.
  - If StallD=1: buf <= {imem_rdata, PCF+4}, and the state moves to HOLD.
- WAIT, on imem_rvalid with discard=1: the data is dropped, discard <= 0, and the state moves to REQ.
- HOLD: when StallD=0, D <= buf with ValidD=1, and the state moves to REQ.
- Redirect (PCSrcM=1) has priority over every other event in all states:
  - PCF <= PCBranchM, and D <= {NOP_INSTR, ValidD=0}, even when StallD=1. PCPlus4D holds.
  - REQ without gnt: stay in REQ, and the next cycle requests the new address.
  - REQ with gnt in the same cycle: go to WAIT with discard <= 1.
  - WAIT without rvalid: discard <= 1; a redirect while discard is already 1 keeps discard=1 and retargets PCF.
  - WAIT with rvalid in the same cycle: the response is dropped, discard <= 0, and the state moves to REQ.
  - HOLD: the buffer is dropped and the state moves to REQ.
- Bubble: in any cycle without a redirect where StallD=0 and no instruction moves into D, D <= {NOP_INSTR, ValidD=0} and PCPlus4D holds.
- StallD=1 with no redirect: InstructionD, PCPlus4D and ValidD hold.
- Arithmetic: PC+4 is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0, with no flag.

## Timing
- Reset values:
  - State REQ, PCF=RESET_PC, discard=0.
  - InstructionD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - imem_req=0 during the reset cycle.
- imem_req and imem_addr are decoded from registered state and PCF only, with no combinational path from imem_gnt or imem_rvalid.
- Latency with a zero-wait memory (gnt in the first REQ cycle, rvalid on the next cycle): the instruction is in D on the edge after rvalid. Best-case throughput is 1 instruction per 2 cycles.
- A redirect seen at edge N drives imem_addr=PCBranchM from cycle N+1, unless the state is WAIT/discard; then it follows the discarded response.
- Reset asserted mid-operation:
  - Any outstanding request is abandoned, and the memory must also be reset.
  - discard clears, and all outputs return to their reset values on the next edge.

## Test plan
- Reset, then a zero-wait memory returning rdata=addr^32'hA5A5_0000: ValidD pulses every 2nd cycle; PCPlus4D goes 4, 8, 12; InstructionD matches each address.
- gnt delayed 3 cycles, rvalid delayed 2 more: imem_req and imem_addr=0 stay stable until gnt; the instruction reaches D on the edge after rvalid; ValidD=0 in between.
- StallD=1 for 4 cycles around rvalid: D holds its prior value, the state enters HOLD, no new imem_req is issued; after release, D gets the buffered word with PCPlus4D=PCF_old+4.
- PCSrcM=1 with PCBranchM=32'h0000_0100 while in WAIT: the next rvalid is dropped, the next request has addr 32'h100, D gets NOP_INSTR with ValidD=0, and the first valid D has PCPlus4D=32'h104.
- Redirect coinciding with gnt, and redirect coinciding with rvalid: neither stale word ever reaches D with ValidD=1; the fetch restarts at PCBranchM.
- Reset asserted during WAIT, and PC wrap from 32'hFFFF_FFFC: outputs return to reset values; after the wrap, the next request address is 0.
